pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register between two stages of the 5-stage MIPS core (F/D, D/E, E/M, M/W).
//  Carries PC, a generic datapath payload and stage control bits with a valid/ready handshake.
//  Has an optional 2-entry skid buffer, synchronous flush and bubble masking of control bits.
//  Has a saturating back-pressure counter for performance debug.
// PARAMETERS
//  DW        128            payload width (IR, RT, ALUOut, imm, WA ... concatenated by instantiator)
//  CW        4              control width (MemWrite, RegWrite, MemtoReg ...)
//  PC_RESET  32'h0000_3000  out_pc value after reset
//  SKID      1              1: 2-entry skid, registered in_ready; 0: single register, combinational in_ready
//  CNT_W     16             stall counter width
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  flush        in   1      synchronous; discard all held entries (branch/exception kill)
//  in_valid     in   1      upstream entry present
//  in_ready     out  1      stage can accept; in_fire = in_valid & in_ready
//  in_pc        in   32     upstream PC+4
//  in_payload   in   DW     upstream datapath bundle
//  in_ctrl      in   CW     upstream control bits
//  out_valid    out  1      entry present at output
//  out_ready    in   1      downstream accepts; out_fire = out_valid & out_ready
//  out_pc       out  32     PC of head entry
//  out_payload  out  DW     payload of head entry
//  out_ctrl     out  CW     control of head entry; forced 0 when out_valid=0
//  occupancy    out  2      entries held (0..2; max 1 when SKID=0)
//  stall_cnt    out  CNT_W  cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset: out_valid=0, out_pc=PC_RESET, out_payload=0, out_ctrl=0, occupancy=0, stall_cnt=0.
//  Reset: in_ready=1 in the cycle after reset.
//  All state updates happen on posedge clk. Priority: reset > flush > handshake.
//  Latency: in_fire in cycle N with stage empty -> out_valid=1 with that data in N+1.
//  Order is strictly FIFO; no entry is lost or duplicated.
//  SKID=1 state machine (head register H, skid register S):
//   EMPTY: in_fire -> H<=in, go ONE.
//   ONE:   in_fire & out_fire  -> H<=in, stay ONE.
//          in_fire & !out_fire -> S<=in, go TWO.
//          !in_fire & out_fire -> go EMPTY.
//          otherwise hold.
//   TWO:   in_ready=0. out_fire -> H<=S, go ONE. otherwise hold.
//   in_ready = (state!=TWO); it is a registered flop with no combinational path from out_ready.
//  SKID=0: in_ready = !out_valid | out_ready (combinational); S is not built; states EMPTY/ONE only.
//  Flush: next state EMPTY, out_valid=0, out_ctrl=0.
//   An entry that fires on the input in the flush cycle is discarded.
//   out_pc and out_payload hold their stale values (don't-care); only ctrl is masked.
//  Bubble masking: out_ctrl == 0 whenever out_valid==0, so no MemWrite/RegWrite on a bubble.
//  Hold: when !out_fire, out_* are stable and bit-identical cycle to cycle.
//  stall_cnt: +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1.
//   Flush does not clear stall_cnt; only reset clears it.
//  Reset mid-operation clears all entries, including a TWO-state skid entry.
// TESTING
//  1 Reset release -> out_valid=0, out_pc=32'h3000, out_ctrl=0, in_ready=1, occupancy=0.
//  2 Streaming, out_ready=1, SKID=1, PCs 0x3004,0x3008,0x300C on consecutive cycles:
//    -> same PCs at output one cycle later each; occupancy=1 throughout.
//  3 out_ready=0, push A=0x3004 then B=0x3008:
//    -> occupancy 2, in_ready=0, out_pc=A; after out_ready=1 for 2 cycles, output A then B; stall_cnt=2.
//  4 In TWO, assert flush with in_valid=1 C=0x300C:
//    -> next cycle occupancy=0, out_valid=0, out_ctrl=0; C is never seen at the output.
//  5 SKID=0, out_ready=0 while holding A, in_valid=1:
//    -> in_ready=0 same cycle; out_ready=1 -> A out, B accepted in that cycle, B valid next cycle.
//  6 CNT_W=4, out_ready=0 for 20 cycles with valid entry -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register between MIPS core stages: PC, payload and control
// with valid/ready handshake, optional 2-entry skid, flush and stall counter.
module pipe_stage_elastic #(
  parameter int unsigned DW       = 128,
  parameter int unsigned CW       = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [DW-1:0]    in_payload,
  input  logic [CW-1:0]    in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [DW-1:0]    out_payload,
  output logic [CW-1:0]    out_ctrl,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]    state;
  logic [31:0]   h_pc;
  logic [DW-1:0] h_payload;
  logic [CW-1:0] h_ctrl;
  logic          in_fire;
  logic          out_fire;

  assign out_valid   = (state != EMPTY);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign out_pc      = h_pc;
  assign out_payload = h_payload;
  // Head ctrl may be stale after flush/drain; masking keeps bubbles harmless.
  assign out_ctrl    = out_valid ? h_ctrl : '0;
  assign occupancy   = state;

  if (SKID != 0) begin : g_skid
    logic [31:0]   s_pc;
    logic [DW-1:0] s_payload;
    logic [CW-1:0] s_ctrl;
    logic          rdy;

    assign in_ready = rdy;

    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= EMPTY;
        rdy       <= 1'b1;
        h_pc      <= PC_RESET;
        h_payload <= '0;
        h_ctrl    <= '0;
      end else if (flush) begin
        state <= EMPTY;
        rdy   <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              h_pc      <= in_pc;
              h_payload <= in_payload;
              h_ctrl    <= in_ctrl;
              state     <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              h_pc      <= in_pc;
              h_payload <= in_payload;
              h_ctrl    <= in_ctrl;
            end else if (in_fire) begin
              state <= TWO;
              rdy   <= 1'b0;
            end else if (out_fire) begin
              state <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              h_pc      <= s_pc;
              h_payload <= s_payload;
              h_ctrl    <= s_ctrl;
              state     <= ONE;
              rdy       <= 1'b1;
            end
          end
          default: begin
            state <= EMPTY;
            rdy   <= 1'b1;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset && !flush && state == ONE && in_fire && !out_fire) begin
        s_pc      <= in_pc;
        s_payload <= in_payload;
        s_ctrl    <= in_ctrl;
      end
    end
  end else begin : g_noskid
    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk) begin
      if (reset) begin
        state     <= EMPTY;
        h_pc      <= PC_RESET;
        h_payload <= '0;
        h_ctrl    <= '0;
      end else if (flush) begin
        state <= EMPTY;
      end else if (in_fire) begin
        h_pc      <= in_pc;
        h_payload <= in_payload;
        h_ctrl    <= in_ctrl;
        state     <= ONE;
      end else if (out_fire) begin
        state <= EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
